// File: rtl/fft_p2s_out.sv
// fft_p2s_out: parallel-to-serial output stage for the 8-point FFT.
// Captures eight complex bins on a load pulse into one of two frame banks.
// Streams them out in order 0..7 over a valid/ready handshake.
// Optional feature macro: FFT_P2S_MAG_EN adds out_mag = |re| + |im|.
// All data outputs are registered. A look-ahead mux selects the word that
// will be presented after each edge. overrun is combinational and is valid
// in the load cycle only.
module fft_p2s_out #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] X_0_re,
    input  logic [WIDTH-1:0] X_1_re,
    input  logic [WIDTH-1:0] X_2_re,
    input  logic [WIDTH-1:0] X_3_re,
    input  logic [WIDTH-1:0] X_4_re,
    input  logic [WIDTH-1:0] X_5_re,
    input  logic [WIDTH-1:0] X_6_re,
    input  logic [WIDTH-1:0] X_7_re,
    input  logic [WIDTH-1:0] X_0_im,
    input  logic [WIDTH-1:0] X_1_im,
    input  logic [WIDTH-1:0] X_2_im,
    input  logic [WIDTH-1:0] X_3_im,
    input  logic [WIDTH-1:0] X_4_im,
    input  logic [WIDTH-1:0] X_5_im,
    input  logic [WIDTH-1:0] X_6_im,
    input  logic [WIDTH-1:0] X_7_im,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             overrun
`ifdef FFT_P2S_MAG_EN
    ,
    output logic [WIDTH:0]   out_mag
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Magnitude of a signed sample, one bit wider so that -2^(WIDTH-1) is exact.
    function automatic logic [WIDTH:0] abs_val(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        if (v[WIDTH-1]) begin
            r = {1'b0, ~v} + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            r = {1'b0, v};
        end
        return r;
    endfunction

    // Frame storage and control state
    logic [WIDTH-1:0] bank_re_r [2][8];
    logic [WIDTH-1:0] bank_im_r [2][8];
    logic             wp_r;
    logic             rp_r;
    logic [1:0]       cnt_r;
    logic [2:0]       idx_r;
    state_t           state_r;

    // Registered output copies
    logic             out_valid_r;
    logic [WIDTH-1:0] out_re_r;
    logic [WIDTH-1:0] out_im_r;
    logic [2:0]       out_idx_r;
    logic             out_last_r;
`ifdef FFT_P2S_MAG_EN
    logic [WIDTH:0]   out_mag_r;
`endif

    // Combinational control
    logic [WIDTH-1:0] x_re_s [8];
    logic [WIDTH-1:0] x_im_s [8];
    logic             xfer_s;
    logic             final_s;
    logic             wr_en_s;
    logic             overrun_s;
    logic [1:0]       next_cnt_s;
    logic             next_wp_s;
    logic             next_rp_s;
    logic [2:0]       next_idx_s;
    logic [WIDTH-1:0] rd_re_s;
    logic [WIDTH-1:0] rd_im_s;
    state_t           next_state_s;

    // Gather the individual bin ports into arrays for indexed access
    always_comb begin
        x_re_s[0] = X_0_re;
        x_re_s[1] = X_1_re;
        x_re_s[2] = X_2_re;
        x_re_s[3] = X_3_re;
        x_re_s[4] = X_4_re;
        x_re_s[5] = X_5_re;
        x_re_s[6] = X_6_re;
        x_re_s[7] = X_7_re;
        x_im_s[0] = X_0_im;
        x_im_s[1] = X_1_im;
        x_im_s[2] = X_2_im;
        x_im_s[3] = X_3_im;
        x_im_s[4] = X_4_im;
        x_im_s[5] = X_5_im;
        x_im_s[6] = X_6_im;
        x_im_s[7] = X_7_im;
    end

    // Handshake, capture/drop decision and next pointer/count values.
    // A load into a full buffer is still accepted when the oldest frame
    // finishes draining in the same cycle. Its bank is the one wp points at.
    always_comb begin
        xfer_s     = (cnt_r != 2'd0) && out_ready;
        final_s    = xfer_s && (idx_r == 3'd7);
        wr_en_s    = load && ((cnt_r != 2'd2) || final_s);
        overrun_s  = load && (cnt_r == 2'd2) && !final_s;
        next_cnt_s = cnt_r + {1'b0, wr_en_s} - {1'b0, final_s};
        next_wp_s  = wp_r ^ wr_en_s;
        next_rp_s  = rp_r ^ final_s;
        if (final_s) begin
            next_idx_s = 3'd0;
        end else if (xfer_s) begin
            next_idx_s = idx_r + 3'd1;
        end else begin
            next_idx_s = idx_r;
        end
    end

    // Look-ahead read: take the word straight from the inputs when the bank
    // about to be presented is the one being written at this edge.
    always_comb begin
        rd_re_s = bank_re_r[next_rp_s][next_idx_s];
        rd_im_s = bank_im_r[next_rp_s][next_idx_s];
        if (wr_en_s && (next_rp_s == wp_r)) begin
            rd_re_s = x_re_s[next_idx_s];
            rd_im_s = x_im_s[next_idx_s];
        end else begin
            rd_re_s = bank_re_r[next_rp_s][next_idx_s];
            rd_im_s = bank_im_r[next_rp_s][next_idx_s];
        end
    end

    // Next-state logic: stream while at least one frame is buffered
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (next_cnt_s != 2'd0) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (next_cnt_s == 2'd0) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, pointers, count and bin index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            wp_r    <= 1'b0;
            rp_r    <= 1'b0;
            cnt_r   <= 2'd0;
            idx_r   <= 3'd0;
        end else begin
            state_r <= next_state_s;
            wp_r    <= next_wp_s;
            rp_r    <= next_rp_s;
            cnt_r   <= next_cnt_s;
            idx_r   <= next_idx_s;
        end
    end

    // Frame banks: capture all sixteen inputs into bank wp on an accepted load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    bank_re_r[b][k] <= '0;
                    bank_im_r[b][k] <= '0;
                end
            end
        end else if (wr_en_s) begin
            for (int k = 0; k < 8; k++) begin
                bank_re_r[wp_r][k] <= x_re_s[k];
                bank_im_r[wp_r][k] <= x_im_s[k];
            end
        end
    end

    // Output registers. Under backpressure the next values equal the
    // current ones, so the outputs hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_re_r    <= '0;
            out_im_r    <= '0;
            out_idx_r   <= 3'd0;
            out_last_r  <= 1'b0;
`ifdef FFT_P2S_MAG_EN
            out_mag_r   <= '0;
`endif
        end else begin
            out_valid_r <= (next_cnt_s != 2'd0);
            out_re_r    <= rd_re_s;
            out_im_r    <= rd_im_s;
            out_idx_r   <= next_idx_s;
            out_last_r  <= (next_cnt_s != 2'd0) && (next_idx_s == 3'd7);
`ifdef FFT_P2S_MAG_EN
            out_mag_r   <= abs_val(rd_re_s) + abs_val(rd_im_s);
`endif
        end
    end

    assign out_valid = out_valid_r;
    assign out_re    = out_re_r;
    assign out_im    = out_im_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign busy      = (state_r == ST_STREAM);
    assign overrun   = overrun_s;
`ifdef FFT_P2S_MAG_EN
    assign out_mag   = out_mag_r;
`endif

endmodule

// File: tb/tb_fft_p2s_out.sv
// Self-checking bench for fft_p2s_out.
// The reference model is a queue of up to two frames plus a read position.
module tb_fft_p2s_out;

    localparam int W = 16;

    typedef struct packed {
        logic [7:0][W-1:0] re;
        logic [7:0][W-1:0] im;
    } frame_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load = 1'b0;
    logic         out_ready = 1'b0;
    frame_t       in_f = '0;
    logic         out_valid;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic [2:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         overrun;
`ifdef FFT_P2S_MAG_EN
    logic [W:0]   out_mag;
`endif

    frame_t mq[$];
    int     pos = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    fft_p2s_out #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .load(load),
        .X_0_re(in_f.re[0]), .X_1_re(in_f.re[1]), .X_2_re(in_f.re[2]), .X_3_re(in_f.re[3]),
        .X_4_re(in_f.re[4]), .X_5_re(in_f.re[5]), .X_6_re(in_f.re[6]), .X_7_re(in_f.re[7]),
        .X_0_im(in_f.im[0]), .X_1_im(in_f.im[1]), .X_2_im(in_f.im[2]), .X_3_im(in_f.im[3]),
        .X_4_im(in_f.im[4]), .X_5_im(in_f.im[5]), .X_6_im(in_f.im[6]), .X_7_im(in_f.im[7]),
        .out_ready(out_ready), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .overrun(overrun)
`ifdef FFT_P2S_MAG_EN
        , .out_mag(out_mag)
`endif
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic frame_t ramp_frame();
        frame_t f;
        for (int k = 0; k < 8; k++) begin
            f.re[k] = W'(k + 1);
            f.im[k] = W'(-(k + 1));
        end
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        logic [31:0] r;
        for (int k = 0; k < 8; k++) begin
            r = $urandom();
            f.re[k] = r[15:0];
            f.im[k] = r[31:16];
        end
        return f;
    endfunction

    function automatic int iabs(input logic [W-1:0] v);
        int a;
        a = $signed(v);
        return (a < 0) ? -a : a;
    endfunction

    // Compare the registered outputs with the head of the model queue
    task automatic check_outputs();
        frame_t f;
        check_val("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        check_val("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            f = mq[0];
            check_val("idx", {29'd0, out_idx}, pos);
            check_val("re", {16'd0, out_re}, {16'd0, f.re[pos]});
            check_val("im", {16'd0, out_im}, {16'd0, f.im[pos]});
            check_val("last", {31'd0, out_last}, {31'd0, pos == 7});
`ifdef FFT_P2S_MAG_EN
            check_val("mag", {15'd0, out_mag}, iabs(f.re[pos]) + iabs(f.im[pos]));
`endif
        end else begin
            check_val("last_idle", {31'd0, out_last}, 32'd0);
        end
    endtask

    // One clock cycle: check, drive, check overrun, advance the model
    task automatic step(input bit ld, input bit rdy, input frame_t fr);
        bit exp_ovr;
        check_outputs();
        load = ld;
        out_ready = rdy;
        in_f = fr;
        #1;
        exp_ovr = ld && (mq.size() == 2) && !(rdy && pos == 7);
        check_val("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        @(posedge clk);
        if (mq.size() != 0 && rdy) begin
            if (pos == 7) begin
                void'(mq.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        if (ld && mq.size() < 2) begin
            mq.push_back(fr);
        end
        @(negedge clk);
        load = 1'b0;
        in_f = rand_frame();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_re"}, {16'd0, out_re}, 32'd0);
        check_val({tag, "_im"}, {16'd0, out_im}, 32'd0);
        check_val({tag, "_idx"}, {29'd0, out_idx}, 32'd0);
        check_val({tag, "_last"}, {31'd0, out_last}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
`ifdef FFT_P2S_MAG_EN
        check_val({tag, "_mag"}, {15'd0, out_mag}, 32'd0);
`endif
    endtask

    initial begin
        frame_t mf;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Single frame at full throughput
        step(1'b1, 1'b1, ramp_frame());
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, rand_frame());

        // Ready toggling: each bin held during its low-ready cycle
        step(1'b1, 1'b0, ramp_frame());
        for (int i = 0; i < 17; i++) step(1'b0, (i % 2) == 0, rand_frame());

        // Three loads two cycles apart with ready low: third overruns
        step(1'b1, 1'b0, rand_frame());
        step(1'b0, 1'b0, rand_frame());
        step(1'b1, 1'b0, rand_frame());
        step(1'b0, 1'b0, rand_frame());
        step(1'b1, 1'b0, rand_frame());
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, rand_frame());

        // Full buffer, load coincides with the bin-7 transfer
        step(1'b1, 1'b0, rand_frame());
        step(1'b1, 1'b0, rand_frame());
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, rand_frame());
        step(1'b1, 1'b1, rand_frame());
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, rand_frame());

        // Magnitude corner values
        mf = ramp_frame();
        mf.re[0] = 16'h8000;
        mf.im[0] = 16'h8000;
        mf.re[1] = 16'd3;
        mf.im[1] = 16'hFFFC;
        step(1'b1, 1'b0, mf);
`ifdef FFT_P2S_MAG_EN
        check_val("mag_min", {15'd0, out_mag}, 32'd65536);
`endif
        step(1'b0, 1'b1, rand_frame());
`ifdef FFT_P2S_MAG_EN
        check_val("mag_3_4", {15'd0, out_mag}, 32'd7);
`endif
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rand_frame());

        // Reset asserted mid-stream at bin 4
        step(1'b1, 1'b1, ramp_frame());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_frame());
        check_val("pre_rst_idx", {29'd0, out_idx}, 32'd4);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        mq.delete();
        pos = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b1, ramp_frame());
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, rand_frame());

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, rand_frame());
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rand_frame());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
